// File: rtl/caliptra_verilated_apb_xactor_if.sv
// Bus bundle for the verilated APB transactor: harness request/response
// streams plus the APB master signals. The master modport is the transactor
// side and the slave modport is the harness/APB-target side.
`ifndef CALIPTRA_APB_ADDR_WIDTH
`define CALIPTRA_APB_ADDR_WIDTH 32
`endif
`ifndef CALIPTRA_APB_DATA_WIDTH
`define CALIPTRA_APB_DATA_WIDTH 32
`endif
`ifndef CALIPTRA_APB_USER_WIDTH
`define CALIPTRA_APB_USER_WIDTH 32
`endif

interface caliptra_verilated_apb_xactor_if;
    logic                                req_valid;
    logic                                req_ready;
    logic                                req_write;
    logic [`CALIPTRA_APB_ADDR_WIDTH-1:0] req_addr;
    logic [`CALIPTRA_APB_DATA_WIDTH-1:0] req_wdata;
    logic [`CALIPTRA_APB_USER_WIDTH-1:0] req_pauser;
    logic                                rsp_valid;
    logic                                rsp_ready;
    logic [`CALIPTRA_APB_DATA_WIDTH-1:0] rsp_rdata;
    logic                                rsp_err;
    logic                                rsp_timeout;
    logic                                busy;
    logic [`CALIPTRA_APB_ADDR_WIDTH-1:0] paddr;
    logic                                psel;
    logic                                penable;
    logic                                pwrite;
    logic [`CALIPTRA_APB_DATA_WIDTH-1:0] pwdata;
    logic [`CALIPTRA_APB_USER_WIDTH-1:0] pauser;
    logic [2:0]                          pprot;
    logic [`CALIPTRA_APB_DATA_WIDTH-1:0] prdata;
    logic                                pready;
    logic                                pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_pauser, rsp_ready,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        output paddr, psel, penable, pwrite, pwdata, pauser, pprot
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_pauser, rsp_ready,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        input  paddr, psel, penable, pwrite, pwdata, pauser, pprot
    );
endinterface

// File: rtl/caliptra_verilated_apb_xactor.sv
// APB master transactor placed in front of the verilated Caliptra top.
// Requests are buffered in a REQ_DEPTH-entry FIFO and executed one at a time
// as SETUP/ACCESS transfers; each produces one in-order response.
// The request being executed keeps its FIFO slot until its response is
// accepted, so REQ_DEPTH counts the in-flight transfer as well. When the
// FIFO is empty in IDLE the incoming request is loaded straight into the APB
// registers, giving SETUP in the cycle right after acceptance.
// Optional feature macro: CALIPTRA_APB_XACTOR_TIMEOUT_EN (ACCESS-phase abort
// after TIMEOUT_CYCLES cycles without pready).
`ifndef CALIPTRA_APB_ADDR_WIDTH
`define CALIPTRA_APB_ADDR_WIDTH 32
`endif
`ifndef CALIPTRA_APB_DATA_WIDTH
`define CALIPTRA_APB_DATA_WIDTH 32
`endif
`ifndef CALIPTRA_APB_USER_WIDTH
`define CALIPTRA_APB_USER_WIDTH 32
`endif

module caliptra_verilated_apb_xactor #(
    parameter int REQ_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                             core_clk,
    input logic                             cptra_rst_b,
    caliptra_verilated_apb_xactor_if.master bus
);
    localparam int AW    = `CALIPTRA_APB_ADDR_WIDTH;
    localparam int DW    = `CALIPTRA_APB_DATA_WIDTH;
    localparam int UW    = `CALIPTRA_APB_USER_WIDTH;
    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(REQ_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    if ((REQ_DEPTH < 2) || ((REQ_DEPTH & (REQ_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("REQ_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {LOAD_NONE, LOAD_HEAD, LOAD_NEXT, LOAD_REQ} load_t;

    logic [AW-1:0]    fifo_addr  [REQ_DEPTH];
    logic [DW-1:0]    fifo_wdata [REQ_DEPTH];
    logic [UW-1:0]    fifo_user  [REQ_DEPTH];
    logic             fifo_write [REQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] sel_ptr;
    logic [CNT_W-1:0] count;
    logic             running;
    logic             fifo_push;
    logic             fifo_pop;

    state_t state;
    state_t state_next;
    load_t  load_sel;
    logic   xfer_done;
    logic   xfer_abort;
    logic   wait_limit;

    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [UW-1:0] sel_user;
    logic          sel_write;

    logic [AW-1:0] apb_addr;
    logic          apb_write;
    logic [DW-1:0] apb_wdata;
    logic [UW-1:0] apb_user;
    logic [DW-1:0] rsp_data;
    logic          rsp_error;
    logic          rsp_tmo;

    // req_ready stays low until the first clock after reset release
    assign bus.req_ready = running && (count != FULL_CNT);
    assign fifo_push     = bus.req_valid && bus.req_ready;

    assign bus.psel        = (state == SETUP) || (state == ACCESS);
    assign bus.penable     = (state == ACCESS);
    assign bus.rsp_valid   = (state == RESP);
    assign bus.busy        = (count != '0) || (state != IDLE);
    assign bus.paddr       = apb_addr;
    assign bus.pwrite      = apb_write;
    assign bus.pwdata      = apb_wdata;
    assign bus.pauser      = apb_user;
    assign bus.pprot       = 3'b000;
    assign bus.rsp_rdata   = rsp_data;
    assign bus.rsp_err     = rsp_error;
    assign bus.rsp_timeout = rsp_tmo;

`ifdef CALIPTRA_APB_XACTOR_TIMEOUT_EN
    logic [31:0] wait_cnt;

    assign wait_limit = (wait_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Count ACCESS cycles without pready; restarts on every SETUP
    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !bus.pready) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end
`else
    assign wait_limit = 1'b0;
`endif

    // Select the request that is about to become the active APB transfer
    always_comb begin
        sel_ptr   = (load_sel == LOAD_NEXT) ? rd_ptr + PTR_W'(1) : rd_ptr;
        sel_addr  = fifo_addr[sel_ptr];
        sel_wdata = fifo_wdata[sel_ptr];
        sel_user  = fifo_user[sel_ptr];
        sel_write = fifo_write[sel_ptr];
        if (load_sel == LOAD_REQ) begin
            sel_addr  = bus.req_addr;
            sel_wdata = bus.req_wdata;
            sel_user  = bus.req_pauser;
            sel_write = bus.req_write;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge core_clk) begin
        if (fifo_push) begin
            fifo_addr[wr_ptr]  <= bus.req_addr;
            fifo_wdata[wr_ptr] <= bus.req_wdata;
            fifo_user[wr_ptr]  <= bus.req_pauser;
            fifo_write[wr_ptr] <= bus.req_write;
        end
    end

    // FIFO pointers, occupancy and post-reset ready enable
    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            running <= 1'b0;
        end else begin
            running <= 1'b1;
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (fifo_push && !fifo_pop) begin
                count <= count + ONE_CNT;
            end else if (!fifo_push && fifo_pop) begin
                count <= count - ONE_CNT;
            end
        end
    end

    // FSM state register
    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state, FIFO pop and APB register load selection
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        load_sel   = LOAD_NONE;
        xfer_done  = 1'b0;
        xfer_abort = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load_sel   = LOAD_HEAD;
                    state_next = SETUP;
                end else if (fifo_push) begin
                    load_sel   = LOAD_REQ;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    xfer_done  = 1'b1;
                    state_next = RESP;
                end else if (wait_limit) begin
                    xfer_abort = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    fifo_pop = 1'b1;
                    if (count > ONE_CNT) begin
                        load_sel   = LOAD_NEXT;
                        state_next = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // APB request registers and captured response
    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            apb_addr  <= '0;
            apb_write <= 1'b0;
            apb_wdata <= '0;
            apb_user  <= '0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            rsp_tmo   <= 1'b0;
        end else begin
            if (load_sel != LOAD_NONE) begin
                apb_addr  <= sel_addr;
                apb_write <= sel_write;
                apb_wdata <= sel_write ? sel_wdata : '0;
                apb_user  <= sel_user;
            end
            if (xfer_done) begin
                rsp_data  <= apb_write ? '0 : bus.prdata;
                rsp_error <= bus.pslverr;
                rsp_tmo   <= 1'b0;
            end else if (xfer_abort) begin
                rsp_data  <= '0;
                rsp_error <= 1'b1;
                rsp_tmo   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_caliptra_verilated_apb_xactor.sv
// Bench for the APB transactor: a scripted harness drives requests, a
// reactive APB slave answers them, and a scoreboard queue holds the response
// expected for every accepted request.
module tb_caliptra_verilated_apb_xactor;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    logic clk;
    logic cptra_rst_b;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rsp_seen = 0;
    exp_t sb[$];
    int   rsp_cyc[$];
    exp_t mon_exp;

    // slave model controls
    int          slv_wait    = 0;
    logic        slv_stall   = 1'b0;
    logic [31:0] slv_key     = 32'h0;
    logic        slv_err_en  = 1'b0;
    logic [31:0] slv_err_addr = 32'h0;
    int          acc_cnt     = 0;

    caliptra_verilated_apb_xactor_if bus();

    caliptra_verilated_apb_xactor #(
        .REQ_DEPTH      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .core_clk    (clk),
        .cptra_rst_b (cptra_rst_b),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // APB slave: answers after slv_wait ACCESS cycles unless stalled
    always @(negedge clk) begin
        if (bus.psel && bus.penable) begin
            if (!slv_stall && acc_cnt >= slv_wait) begin
                bus.pready = 1'b1;
            end else begin
                bus.pready = 1'b0;
                acc_cnt++;
            end
        end else begin
            bus.pready = 1'b0;
            acc_cnt = 0;
        end
        bus.prdata  = bus.paddr ^ slv_key;
        bus.pslverr = slv_err_en && (bus.paddr == slv_err_addr);
    end

    // Response monitor: compare every accepted response against the scoreboard
    always @(negedge clk) begin
        if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_seen++;
            rsp_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                mon_exp = sb.pop_front();
                check("rsp_rdata", bus.rsp_rdata, mon_exp.rdata);
                check("rsp_err", bus.rsp_err, mon_exp.err);
                check("rsp_timeout", bus.rsp_timeout, mon_exp.tmo);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind: 0 normal completion expected, 1 timeout abort expected, 2 no response expected
    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] user, input int kind);
        int   guard = 0;
        exp_t e;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_pauser = user;
        @(negedge clk);
        while (!bus.req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check("req_accept_bound", 0, 1);
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            if (kind == 0) begin
                e.rdata = wr ? 32'h0 : (addr ^ slv_key);
                e.err   = slv_err_en && (addr == slv_err_addr);
                e.tmo   = 1'b0;
                sb.push_back(e);
            end else if (kind == 1) begin
                e.rdata = 32'h0;
                e.err   = 1'b1;
                e.tmo   = 1'b1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int guard = 0;
        while ((bus.busy || sb.size() != 0) && guard < 500) begin
            wait_cycles(1);
            guard++;
        end
        check(tag, bus.busy, 0);
    endtask

    task automatic count_psel(output int n);
        n = 0;
        while (bus.psel && n < 2000) begin
            n++;
            wait_cycles(1);
        end
    endtask

    initial begin
        int n;
        int early;
        int base_seen;
        int base_idx;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_pauser = 32'h0;
        bus.rsp_ready  = 1'b1;
        cptra_rst_b    = 1'b0;

        // reset state
        wait_cycles(3);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_psel", bus.psel, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_paddr", bus.paddr, 0);
        check("rst_pprot", bus.pprot, 0);
        cptra_rst_b = 1'b1;
        wait_cycles(2);
        check("post_rst_req_ready", bus.req_ready, 1);

        // 1: zero-wait write
        slv_wait = 0;
        drive_req(1'b1, 32'h3003_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0);
        check("t1_setup_psel", bus.psel, 1);
        check("t1_setup_penable", bus.penable, 0);
        check("t1_pwrite", bus.pwrite, 1);
        check("t1_paddr", bus.paddr, 32'h3003_0000);
        check("t1_pwdata", bus.pwdata, 32'hDEAD_BEEF);
        check("t1_pauser", bus.pauser, 32'hFFFF_FFFF);
        wait_cycles(1);
        check("t1_access_penable", bus.penable, 1);
        check("t1_access_paddr", bus.paddr, 32'h3003_0000);
        wait_cycles(1);
        check("t1_rsp_valid", bus.rsp_valid, 1);
        check("t1_psel_resp", bus.psel, 0);
        check("t1_rsp_rdata", bus.rsp_rdata, 0);
        check("t1_rsp_err", bus.rsp_err, 0);
        wait_cycles(1);
        check("t1_idle_busy", bus.busy, 0);

        // 2: read with 5 wait states
        slv_wait = 5;
        slv_key  = 32'h1234_5678 ^ 32'h3003_0008;
        drive_req(1'b0, 32'h3003_0008, 32'hAAAA_AAAA, 32'h1, 0);
        check("t2_pwdata_read", bus.pwdata, 0);
        check("t2_pwrite", bus.pwrite, 0);
        count_psel(n);
        check("t2_psel_cycles", n, 7);
        check("t2_rsp_valid", bus.rsp_valid, 1);
        check("t2_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
        wait_idle("t2_idle");

        // 3: fill FIFO with a stalled slave, then drain back-to-back
        slv_wait  = 0;
        slv_key   = 32'h5A5A_0000;
        slv_stall = 1'b1;
        base_seen = rsp_seen;
        base_idx  = rsp_cyc.size();
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b0, 32'h0000_0100 + 32'(i * 4), 32'h0, 32'h2, 0);
        end
        check("t3_full_ready", bus.req_ready, 0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0110;
        early = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req_ready) early++;
        end
        check("t3_full_holds", early, 0);
        slv_stall = 1'b0;
        drive_req(1'b0, 32'h0000_0110, 32'h0, 32'h2, 0);
        check("t3_fifth_after_pop", (rsp_seen - base_seen) >= 1, 1);
        wait_idle("t3_idle");
        check("t3_rsp_count", rsp_cyc.size() - base_idx, 5);
        if (rsp_cyc.size() - base_idx == 5) begin
            for (int i = 1; i < 5; i++) begin
                check("t3_b2b_gap", rsp_cyc[base_idx + i] - rsp_cyc[base_idx + i - 1], 3);
            end
        end

        // 4: slave error on a read, following write still runs
        slv_err_en   = 1'b1;
        slv_err_addr = 32'h0000_0200;
        slv_stall    = 1'b1;
        drive_req(1'b0, 32'h0000_0200, 32'h0, 32'h3, 0);
        drive_req(1'b1, 32'h0000_0204, 32'hCAFE_F00D, 32'h3, 0);
        slv_stall = 1'b0;
        wait_idle("t4_idle");
        slv_err_en = 1'b0;

        // 5: slave never ready
        slv_stall = 1'b1;
`ifdef CALIPTRA_APB_XACTOR_TIMEOUT_EN
        drive_req(1'b0, 32'h0000_0300, 32'h0, 32'h4, 1);
        count_psel(n);
        check("t5_psel_cycles", n, 17);
        check("t5_rsp_timeout", bus.rsp_timeout, 1);
        wait_idle("t5_idle");
        drive_req(1'b0, 32'h0000_0400, 32'h0, 32'h5, 2);
`else
        drive_req(1'b0, 32'h0000_0300, 32'h0, 32'h4, 2);
        wait_cycles(1000);
        check("t5_still_access", bus.psel && bus.penable, 1);
        check("t5_no_rsp", bus.rsp_valid, 0);
        check("t5_timeout_tied", bus.rsp_timeout, 0);
`endif

        // 6: reset during ACCESS with two requests queued
        drive_req(1'b0, 32'h0000_0404, 32'h0, 32'h5, 2);
        drive_req(1'b1, 32'h0000_0408, 32'h1, 32'h5, 2);
        wait_cycles(2);
        check("t6_pre_penable", bus.penable, 1);
        cptra_rst_b = 1'b0;
        #1;
        check("t6_rst_psel", bus.psel, 0);
        check("t6_rst_penable", bus.penable, 0);
        check("t6_rst_rsp_valid", bus.rsp_valid, 0);
        check("t6_rst_busy", bus.busy, 0);
        sb.delete();
        wait_cycles(2);
        slv_stall   = 1'b0;
        cptra_rst_b = 1'b1;
        base_seen   = rsp_seen;
        early = 0;
        for (int i = 0; i < 20; i++) begin
            wait_cycles(1);
            if (bus.psel) early++;
        end
        check("t6_no_stale_psel", early, 0);
        check("t6_no_stale_rsp", rsp_seen - base_seen, 0);
        check("t6_busy", bus.busy, 0);

        // post-reset transfer works normally
        drive_req(1'b1, 32'h3003_0010, 32'h0BAD_CAFE, 32'h6, 0);
        check("t6_new_paddr", bus.paddr, 32'h3003_0010);
        wait_idle("t6_final_idle");
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 100000", cyc);
        $fatal(1, "watchdog");
    end
endmodule
